async_fifo_rd_ctrl: RTL and testbench

Read-side controller for the async FIFO, running entirely in the read clock domain. It turns the synchronized write pointer into an empty decision and fetches words from the dual-port RAM's registered read port. Words are presented to the consumer on a valid/ready interface through a 2-entry output buffer. It also exports the Gray-coded read pointer for synchronization back to the write side.

---
 rtl/async_fifo_pkg.sv | 26 ++
 rtl/fifo_out_skid.sv | 81 ++++++++
 rtl/async_fifo_rd_ctrl.sv | 85 ++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared async FIFO pointer helpers and output-buffer state type
package async_fifo_pkg;

   localparam int FN_W = 32;

   typedef enum logic [1:0] {
      OB_EMPTY = 2'd0,
      OB_ONE   = 2'd1,
      OB_TWO   = 2'd2
   } ob_state_t;

   // Operands are zero-extended to FN_W; callers size-cast the result back to pointer width.
   function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
      logic [FN_W-1:0] b;
      b = '0;
      for (int i = 0; i < FN_W; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// rtl/fifo_out_skid.sv - 2-entry output buffer (head + skid) with valid/ready and capture port
module fifo_out_skid
   import async_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_cap_valid,
   input  logic [DATA_WIDTH-1:0] i_cap_data,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic [1:0]            o_ocnt,
   output logic [1:0]            o_ocnt_next
);

   ob_state_t             r_state;
   ob_state_t             w_state_nxt;
   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_skid;
   logic [DATA_WIDTH-1:0] w_head_nxt;
   logic [DATA_WIDTH-1:0] w_skid_nxt;
   logic                  w_pop;

   assign w_pop = (r_state != OB_EMPTY) && i_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= OB_EMPTY;
         r_head  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_head  <= w_head_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

   // The fetch decision upstream guarantees no capture arrives while full and not popping.
   always_comb begin
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_skid_nxt  = r_skid;
      case (r_state)
         OB_EMPTY: begin
            if (i_cap_valid) begin
               w_head_nxt  = i_cap_data;
               w_state_nxt = OB_ONE;
            end
         end
         OB_ONE: begin
            if (w_pop && i_cap_valid) begin
               w_head_nxt = i_cap_data;
            end else if (w_pop) begin
               w_state_nxt = OB_EMPTY;
            end else if (i_cap_valid) begin
               w_skid_nxt  = i_cap_data;
               w_state_nxt = OB_TWO;
            end
         end
         OB_TWO: begin
            if (w_pop) begin
               w_head_nxt = r_skid;
               if (i_cap_valid) begin
                  w_skid_nxt = i_cap_data;
               end else begin
                  w_state_nxt = OB_ONE;
               end
            end
         end
         default: w_state_nxt = OB_EMPTY;
      endcase
   end

   assign o_data      = r_head;
   assign o_valid     = (r_state != OB_EMPTY);
   assign o_ocnt      = r_state;
   assign o_ocnt_next = w_state_nxt;

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// rtl/async_fifo_rd_ctrl.sv - async FIFO read-side controller: empty detect, RAM fetch, output buffer
module async_fifo_rd_ctrl
   import async_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic [ADDR_WIDTH:0]   wr_ptr_gray_sync,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [ADDR_WIDTH:0]   rd_ptr_gray,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   rd_level
);

   localparam int PW = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH:0] r_rbin;
   logic [ADDR_WIDTH:0] r_rd_ptr_gray;
   logic [ADDR_WIDTH:0] r_rd_level;
   logic                r_f;
   logic [ADDR_WIDTH:0] w_wbin_s;
   logic [ADDR_WIDTH:0] w_rbin_nxt;
   logic [ADDR_WIDTH:0] w_level_nxt;
   logic                w_ptr_empty;
   logic                w_fetch;
   logic                w_pop;
   logic                w_dout_valid;
   logic [1:0]          w_ocnt;
   logic [1:0]          w_ocnt_nxt;
   logic [2:0]          w_occ;

   assign w_wbin_s    = PW'(gray2bin(32'(wr_ptr_gray_sync)));
   assign w_ptr_empty = (r_rbin == w_wbin_s);
   assign w_pop       = w_dout_valid & dout_ready;

   // Buffered plus in-flight words may never exceed the two buffer slots after this cycle's pop.
   assign w_occ   = {1'b0, w_ocnt} + {2'b0, r_f};
   assign w_fetch = !rd_rst && !w_ptr_empty && (w_occ < (3'd2 + {2'b0, w_pop}));

   assign w_rbin_nxt  = r_rbin + {{ADDR_WIDTH{1'b0}}, w_fetch};
   assign w_level_nxt = (w_wbin_s - w_rbin_nxt) + PW'(w_ocnt_nxt) + PW'(w_fetch);

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         r_rbin        <= '0;
         r_f           <= 1'b0;
         r_rd_ptr_gray <= '0;
         r_rd_level    <= '0;
      end else begin
         r_rbin        <= w_rbin_nxt;
         r_f           <= w_fetch;
         r_rd_ptr_gray <= PW'(bin2gray(32'(w_rbin_nxt)));
         r_rd_level    <= w_level_nxt;
      end
   end

   fifo_out_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_skid (
      .i_clk       (rd_clk),
      .i_rst       (rd_rst),
      .i_cap_valid (r_f),
      .i_cap_data  (ram_rd_data),
      .i_ready     (dout_ready),
      .o_data      (dout),
      .o_valid     (w_dout_valid),
      .o_ocnt      (w_ocnt),
      .o_ocnt_next (w_ocnt_nxt)
   );

   assign ram_rd_en   = w_fetch;
   assign ram_rd_addr = r_rbin[ADDR_WIDTH-1:0];
   assign rd_ptr_gray = r_rd_ptr_gray;
   assign rd_level    = r_rd_level;
   assign dout_valid  = w_dout_valid;
   assign empty       = !w_dout_valid;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// tb/tb_async_fifo_rd_ctrl.sv - directed self-checking bench for async_fifo_rd_ctrl
module tb_async_fifo_rd_ctrl;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rd_rst;
   logic [AW:0]   wr_g;
   logic          ram_rd_en;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data = '0;
   logic [AW:0]   rd_ptr_gray;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready;
   logic          empty;
   logic [AW:0]   rd_level;

   logic [DW-1:0] mem [16];
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int fa[$];
   int fc[$];
   int pd[$];
   int pc[$];
   logic [AW:0] wrap_gray [4];

   always #5 clk = ~clk;

   async_fifo_rd_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .rd_clk           (clk),
      .rd_rst           (rd_rst),
      .wr_ptr_gray_sync (wr_g),
      .ram_rd_en        (ram_rd_en),
      .ram_rd_addr      (ram_rd_addr),
      .ram_rd_data      (ram_rd_data),
      .rd_ptr_gray      (rd_ptr_gray),
      .dout             (dout),
      .dout_valid       (dout_valid),
      .dout_ready       (dout_ready),
      .empty            (empty),
      .rd_level         (rd_level)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
   end

   always @(negedge clk) begin
      if (ram_rd_en) begin
         fa.push_back(int'(ram_rd_addr));
         fc.push_back(cyc);
      end
      if (dout_valid && dout_ready) begin
         pd.push_back(int'(dout));
         pc.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q;
      fa.delete();
      fc.delete();
      pd.delete();
      pc.delete();
   endtask

   task automatic do_reset;
      tick;
      rd_rst = 1'b1;
      wr_g = '0;
      dout_ready = 1'b0;
      tick;
      rd_rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      rd_rst = 1'b1;
      wr_g = '0;
      dout_ready = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[0] = 8'hA5;

      // reset held three cycles, then a fourth with a non-empty pointer
      repeat (3) begin
         tick;
         #1;
         check_eq("rst_rd_en", ram_rd_en, 0);
      end
      tick;
      wr_g = 5'b00001;
      #1;
      check_eq("rst_gate_rd_en", ram_rd_en, 0);
      check_eq("rst_dout", dout, 0);
      check_eq("rst_valid", dout_valid, 0);
      check_eq("rst_empty", empty, 1);
      check_eq("rst_gray", rd_ptr_gray, 0);
      check_eq("rst_level", rd_level, 0);

      // single word
      tick;
      rd_rst = 1'b0;
      #1;
      check_eq("single_rd_en_N", ram_rd_en, 1);
      check_eq("single_addr_N", ram_rd_addr, 0);
      tick;
      #1;
      check_eq("single_gray_N1", rd_ptr_gray, 5'b00001);
      check_eq("single_level_N1", rd_level, 1);
      check_eq("single_rd_en_N1", ram_rd_en, 0);
      check_eq("single_valid_N1", dout_valid, 0);
      tick;
      #1;
      check_eq("single_valid_N2", dout_valid, 1);
      check_eq("single_dout_N2", dout, 8'hA5);
      check_eq("single_empty_N2", empty, 0);
      check_eq("single_level_N2", rd_level, 1);
      dout_ready = 1'b1;
      tick;
      #1;
      check_eq("single_empty_after_pop", empty, 1);
      check_eq("single_valid_after_pop", dout_valid, 0);
      check_eq("single_no_refetch", ram_rd_en, 0);
      check_eq("single_level_after_pop", rd_level, 0);
      dout_ready = 1'b0;

      // full-depth stream
      for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
      do_reset;
      clear_q;
      wr_g = 5'b11000;
      dout_ready = 1'b1;
      repeat (22) tick;
      #1;
      check_eq("stream_fetch_cnt", fa.size(), 16);
      check_eq("stream_pop_cnt", pd.size(), 16);
      for (int i = 0; i < 16; i++) begin
         if (i < fa.size()) begin
            check_eq($sformatf("stream_addr%0d", i), fa[i], i);
            check_eq($sformatf("stream_fcyc%0d", i), fc[i], fc[0] + i);
         end
         if (i < pd.size()) begin
            check_eq($sformatf("stream_data%0d", i), pd[i], 8'h10 + i);
            check_eq($sformatf("stream_pcyc%0d", i), pc[i], pc[0] + i);
         end
      end
      if (fa.size() > 0 && pd.size() > 0) check_eq("stream_latency", pc[0] - fc[0], 2);
      check_eq("stream_gray_end", rd_ptr_gray, 5'b11000);
      check_eq("stream_level_end", rd_level, 0);

      // backpressure: four words available, consumer stalled
      for (int i = 0; i < 4; i++) mem[i] = 8'hC0 + 8'(i);
      do_reset;
      clear_q;
      wr_g = 5'b00110;
      dout_ready = 1'b0;
      tick;
      tick;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_eq($sformatf("bp_hold_valid%0d", k), dout_valid, 1);
         check_eq($sformatf("bp_hold_dout%0d", k), dout, 8'hC0);
         tick;
      end
      #1;
      check_eq("bp_fetch_cnt_stalled", fa.size(), 2);
      check_eq("bp_rd_en_stalled", ram_rd_en, 0);
      check_eq("bp_level_stalled", rd_level, 4);
      dout_ready = 1'b1;
      repeat (8) tick;
      #1;
      check_eq("bp_fetch_cnt", fa.size(), 4);
      check_eq("bp_pop_cnt", pd.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < fa.size()) check_eq($sformatf("bp_addr%0d", i), fa[i], i);
         if (i < pd.size()) begin
            check_eq($sformatf("bp_data%0d", i), pd[i], 8'hC0 + i);
            check_eq($sformatf("bp_pcyc%0d", i), pc[i], pc[0] + i);
         end
      end

      // pointer wrap: drain 30 words, then 4 more across the 31->0 boundary
      for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i);
      wrap_gray[0] = 5'b10000;
      wrap_gray[1] = 5'b00000;
      wrap_gray[2] = 5'b00001;
      wrap_gray[3] = 5'b00011;
      do_reset;
      dout_ready = 1'b1;
      wr_g = 5'b11000;
      repeat (20) tick;
      wr_g = 5'b10001;
      repeat (20) tick;
      #1;
      check_eq("wrap_gray_at30", rd_ptr_gray, 5'b10001);
      check_eq("wrap_empty_at30", empty, 1);
      check_eq("wrap_level_at30", rd_level, 0);
      clear_q;
      tick;
      wr_g = 5'b00011;
      for (int k = 0; k < 4; k++) begin
         tick;
         #1;
         check_eq($sformatf("wrap_gray_step%0d", k), rd_ptr_gray, wrap_gray[k]);
      end
      repeat (4) tick;
      #1;
      check_eq("wrap_fetch_cnt", fa.size(), 4);
      check_eq("wrap_pop_cnt", pd.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < fa.size()) check_eq($sformatf("wrap_addr%0d", i), fa[i], (14 + i) % 16);
         if (i < pd.size()) begin
            check_eq($sformatf("wrap_data%0d", i), pd[i], 8'h30 + ((14 + i) % 16));
            check_eq($sformatf("wrap_pcyc%0d", i), pc[i], pc[0] + i);
         end
      end
      check_eq("wrap_level_end", rd_level, 0);

      // reset while a word is buffered and another is in flight
      for (int i = 0; i < 16; i++) mem[i] = 8'h50 + 8'(i);
      do_reset;
      wr_g = 5'b00110;
      dout_ready = 1'b0;
      tick;
      tick;
      #1;
      check_eq("midrst_pre_valid", dout_valid, 1);
      rd_rst = 1'b1;
      tick;
      rd_rst = 1'b0;
      wr_g = '0;
      #1;
      check_eq("midrst_valid", dout_valid, 0);
      check_eq("midrst_gray", rd_ptr_gray, 0);
      check_eq("midrst_dout", dout, 0);
      check_eq("midrst_level", rd_level, 0);
      check_eq("midrst_rd_en", ram_rd_en, 0);
      for (int k = 0; k < 3; k++) begin
         tick;
         #1;
         check_eq($sformatf("midrst_late_valid%0d", k), dout_valid, 0);
         check_eq($sformatf("midrst_late_dout%0d", k), dout, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
